// File: rtl/rv_ctrl_pkg.sv
`default_nettype none
//----------------------------------------------------------------------------
// Module   : rv_ctrl_pkg
// Purpose  : Shared constants and types for the multicycle RV32I control
//            path. Includes opcodes, aluop encodings, datapath mux selects
//            and the control FSM state enum.
// Ports    : none (package)
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
package rv_ctrl_pkg;

   localparam int CTRL_STATE_W = 4;

   // Major opcodes recognised by the control FSM
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   // aluop encodings, shared with alu_control
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // Memory address select
   localparam logic ADR_PC     = 1'b0;
   localparam logic ADR_ALUOUT = 1'b1;

   // ALU A select
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   // ALU B select
   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   // Result select
   localparam logic [1:0] RES_ALUOUT  = 2'b00;
   localparam logic [1:0] RES_MEMDATA = 2'b01;
   localparam logic [1:0] RES_ALURES  = 2'b10;

   // FETCH is encoded as zero so the debug state reads 0 while in reset.
   typedef enum logic [CTRL_STATE_W-1:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_JAL      = 4'd9,
      S_BEQ      = 4'd10
   } state_t;

   function automatic logic is_supported(input logic [6:0] op);
      return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_R) ||
             (op == OP_I) || (op == OP_JAL) || (op == OP_BRANCH);
   endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_control_decode.sv
`default_nettype none
//----------------------------------------------------------------------------
// Module   : multicycle_control_decode
// Purpose  : Pure combinational decoder that maps the control FSM state to
//            datapath strobes and mux selects. irwrite and the fetch PC
//            update follow mem_ready. A branch writes the PC only when
//            the zero flag is set.
// Ports    : state (in), mem_ready (in), zero (in);
//            mem_req, adrsrc, irwrite, pcwrite, regwrite, memwrite,
//            alusrca, alusrcb, resultsrc, aluop (out)
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
module multicycle_control_decode
   import rv_ctrl_pkg::*;
(
   input  logic [CTRL_STATE_W-1:0] state,
   input  logic                    mem_ready,
   input  logic                    zero,
   output logic                    mem_req,
   output logic                    adrsrc,
   output logic                    irwrite,
   output logic                    pcwrite,
   output logic                    regwrite,
   output logic                    memwrite,
   output logic [1:0]              alusrca,
   output logic [1:0]              alusrcb,
   output logic [1:0]              resultsrc,
   output logic [1:0]              aluop
);

   logic pcupdate;
   logic branch;

   always_comb begin
      mem_req   = 1'b0;
      adrsrc    = ADR_PC;
      irwrite   = 1'b0;
      pcupdate  = 1'b0;
      branch    = 1'b0;
      regwrite  = 1'b0;
      memwrite  = 1'b0;
      alusrca   = SRCA_PC;
      alusrcb   = SRCB_RS2;
      resultsrc = RES_ALUOUT;
      aluop     = ALUOP_ADD;

      case (state)
         S_FETCH: begin
            mem_req   = 1'b1;
            alusrcb   = SRCB_FOUR;
            resultsrc = RES_ALURES;
            // IR load and PC+4 commit only when the fetch actually completes
            irwrite   = mem_ready;
            pcupdate  = mem_ready;
         end
         S_DECODE: begin
            // Branch target is precomputed into ALUOut here
            alusrca = SRCA_OLDPC;
            alusrcb = SRCB_IMM;
         end
         S_MEMADR: begin
            alusrca = SRCA_RS1;
            alusrcb = SRCB_IMM;
         end
         S_MEMREAD: begin
            mem_req = 1'b1;
            adrsrc  = ADR_ALUOUT;
         end
         S_MEMWB: begin
            resultsrc = RES_MEMDATA;
            regwrite  = 1'b1;
         end
         S_MEMWRITE: begin
            mem_req  = 1'b1;
            adrsrc   = ADR_ALUOUT;
            memwrite = 1'b1;
         end
         S_EXECUTER: begin
            alusrca = SRCA_RS1;
            alusrcb = SRCB_RS2;
            aluop   = ALUOP_FUNCT;
         end
         S_EXECUTEI: begin
            alusrca = SRCA_RS1;
            alusrcb = SRCB_IMM;
            aluop   = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            regwrite = 1'b1;
         end
         S_JAL: begin
            alusrca  = SRCA_OLDPC;
            alusrcb  = SRCB_FOUR;
            pcupdate = 1'b1;
         end
         S_BEQ: begin
            alusrca = SRCA_RS1;
            alusrcb = SRCB_RS2;
            aluop   = ALUOP_SUB;
            branch  = 1'b1;
         end
         default: ;  // unused encodings drive nothing
      endcase
   end

   assign pcwrite = pcupdate | (branch & zero);

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
//----------------------------------------------------------------------------
// Module   : multicycle_control
// Purpose  : Main control FSM of the multicycle RV32I core. Sequences the
//            datapath and produces aluop for alu_control. It also handles
//            the memory ready handshake and flags unsupported opcodes with
//            a one-cycle registered pulse.
// Ports    : clk, rst (async, active-high), opcode[6:0], zero, mem_ready (in)
//            mem_req, adrsrc, irwrite, pcwrite, regwrite, memwrite,
//            alusrca[1:0], alusrcb[1:0], resultsrc[1:0], aluop[1:0],
//            illegal_instr, state_dbg[STATE_W-1:0] (out)
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
module multicycle_control
   import rv_ctrl_pkg::*;
#(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [6:0]         opcode,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               mem_req,
   output logic               adrsrc,
   output logic               irwrite,
   output logic               pcwrite,
   output logic               regwrite,
   output logic               memwrite,
   output logic [1:0]         alusrca,
   output logic [1:0]         alusrcb,
   output logic [1:0]         resultsrc,
   output logic [1:0]         aluop,
   output logic               illegal_instr,
   output logic [STATE_W-1:0] state_dbg
);

   state_t state;
   state_t state_next;
   logic   illegal_next;

   logic       dec_mem_req;
   logic       dec_adrsrc;
   logic       dec_irwrite;
   logic       dec_pcwrite;
   logic       dec_regwrite;
   logic       dec_memwrite;
   logic [1:0] dec_alusrca;
   logic [1:0] dec_alusrcb;
   logic [1:0] dec_resultsrc;
   logic [1:0] dec_aluop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= S_FETCH;
         illegal_instr <= 1'b0;
      end else begin
         state         <= state_next;
         illegal_instr <= illegal_next;
      end
   end

   always_comb begin
      state_next   = S_FETCH;
      illegal_next = 1'b0;
      case (state)
         S_FETCH:    state_next = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               OP_LOAD,
               OP_STORE:  state_next = S_MEMADR;
               OP_R:      state_next = S_EXECUTER;
               OP_I:      state_next = S_EXECUTEI;
               OP_JAL:    state_next = S_JAL;
               OP_BRANCH: state_next = S_BEQ;
               default:   state_next = S_FETCH;
            endcase
            illegal_next = !is_supported(opcode);
         end
         // opcode[5] separates store (1) from load (0)
         S_MEMADR:   state_next = opcode[5] ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  state_next = mem_ready ? S_MEMWB : S_MEMREAD;
         S_MEMWB:    state_next = S_FETCH;
         S_MEMWRITE: state_next = mem_ready ? S_FETCH : S_MEMWRITE;
         S_EXECUTER: state_next = S_ALUWB;
         S_EXECUTEI: state_next = S_ALUWB;
         S_ALUWB:    state_next = S_FETCH;
         S_JAL:      state_next = S_ALUWB;
         S_BEQ:      state_next = S_FETCH;
         default:    state_next = S_FETCH;
      endcase
   end

   multicycle_control_decode u_decode (
      .state     (state),
      .mem_ready (mem_ready),
      .zero      (zero),
      .mem_req   (dec_mem_req),
      .adrsrc    (dec_adrsrc),
      .irwrite   (dec_irwrite),
      .pcwrite   (dec_pcwrite),
      .regwrite  (dec_regwrite),
      .memwrite  (dec_memwrite),
      .alusrca   (dec_alusrca),
      .alusrcb   (dec_alusrcb),
      .resultsrc (dec_resultsrc),
      .aluop     (dec_aluop)
   );

   // FETCH still drives mem_req and the fetch selects. So every output is
   // masked while rst is high, which also blocks late writes on an abort.
   assign mem_req   = dec_mem_req  & ~rst;
   assign adrsrc    = dec_adrsrc   & ~rst;
   assign irwrite   = dec_irwrite  & ~rst;
   assign pcwrite   = dec_pcwrite  & ~rst;
   assign regwrite  = dec_regwrite & ~rst;
   assign memwrite  = dec_memwrite & ~rst;
   assign alusrca   = rst ? 2'b00 : dec_alusrca;
   assign alusrcb   = rst ? 2'b00 : dec_alusrcb;
   assign resultsrc = rst ? 2'b00 : dec_resultsrc;
   assign aluop     = rst ? 2'b00 : dec_aluop;

   assign state_dbg = STATE_W'(state);

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
//----------------------------------------------------------------------------
// Module   : tb_multicycle_control
// Purpose  : Directed testbench for multicycle_control. The driver applies
//            one input set per clock and queues the outputs expected in that
//            cycle. The monitor pops and compares them on the falling edge.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
module tb_multicycle_control;

   // State encodings as seen on state_dbg
   localparam logic [3:0] T_FETCH    = 4'd0;
   localparam logic [3:0] T_DECODE   = 4'd1;
   localparam logic [3:0] T_MEMADR   = 4'd2;
   localparam logic [3:0] T_MEMREAD  = 4'd3;
   localparam logic [3:0] T_MEMWB    = 4'd4;
   localparam logic [3:0] T_MEMWRITE = 4'd5;
   localparam logic [3:0] T_EXECUTER = 4'd6;
   localparam logic [3:0] T_EXECUTEI = 4'd7;
   localparam logic [3:0] T_ALUWB    = 4'd8;
   localparam logic [3:0] T_JAL      = 4'd9;
   localparam logic [3:0] T_BEQ      = 4'd10;

   localparam logic [6:0] O_LOAD  = 7'b0000011;
   localparam logic [6:0] O_STORE = 7'b0100011;
   localparam logic [6:0] O_R     = 7'b0110011;
   localparam logic [6:0] O_I     = 7'b0010011;
   localparam logic [6:0] O_JAL   = 7'b1101111;
   localparam logic [6:0] O_BEQ   = 7'b1100011;
   localparam logic [6:0] O_SYS   = 7'b1110011;

   logic       clk;
   logic       rst;
   logic [6:0] opcode;
   logic       zero;
   logic       mem_ready;
   logic       mem_req, adrsrc, irwrite, pcwrite, regwrite, memwrite;
   logic [1:0] alusrca, alusrcb, resultsrc, aluop;
   logic       illegal_instr;
   logic [3:0] state_dbg;

   multicycle_control #(.STATE_W(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .opcode        (opcode),
      .zero          (zero),
      .mem_ready     (mem_ready),
      .mem_req       (mem_req),
      .adrsrc        (adrsrc),
      .irwrite       (irwrite),
      .pcwrite       (pcwrite),
      .regwrite      (regwrite),
      .memwrite      (memwrite),
      .alusrca       (alusrca),
      .alusrcb       (alusrcb),
      .resultsrc     (resultsrc),
      .aluop         (aluop),
      .illegal_instr (illegal_instr),
      .state_dbg     (state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {state, mem_req, adrsrc, irwrite, pcwrite, regwrite, memwrite,
   //  alusrca, alusrcb, resultsrc, aluop, illegal_instr}
   logic [18:0] actual;
   assign actual = {state_dbg, mem_req, adrsrc, irwrite, pcwrite, regwrite,
                    memwrite, alusrca, alusrcb, resultsrc, aluop, illegal_instr};

   logic [18:0] exp_q[$];
   logic [18:0] exp_cur;
   int          vectors     = 0;
   int          miscompares = 0;

   // Output table for each state, taken directly from the state descriptions
   function automatic logic [18:0] expect_vec(input logic [3:0] st, input logic r,
                                              input logic mr, input logic z,
                                              input logic ill);
      logic       mq, ad, irw, pcw, rw, mw;
      logic [1:0] sa, sb, rs, ao;
      mq = 0; ad = 0; irw = 0; pcw = 0; rw = 0; mw = 0;
      sa = 2'b00; sb = 2'b00; rs = 2'b00; ao = 2'b00;
      if (!r) begin
         case (st)
            T_FETCH:    begin mq = 1; irw = mr; pcw = mr; sb = 2'b10; rs = 2'b10; end
            T_DECODE:   begin sa = 2'b01; sb = 2'b01; end
            T_MEMADR:   begin sa = 2'b10; sb = 2'b01; end
            T_MEMREAD:  begin mq = 1; ad = 1; end
            T_MEMWB:    begin rs = 2'b01; rw = 1; end
            T_MEMWRITE: begin mq = 1; ad = 1; mw = 1; end
            T_EXECUTER: begin sa = 2'b10; ao = 2'b10; end
            T_EXECUTEI: begin sa = 2'b10; sb = 2'b01; ao = 2'b10; end
            T_ALUWB:    begin rw = 1; end
            T_JAL:      begin sa = 2'b01; sb = 2'b10; pcw = 1; end
            T_BEQ:      begin sa = 2'b10; ao = 2'b01; pcw = z; end
            default: ;
         endcase
      end
      return {st, mq, ad, irw, pcw, rw, mw, sa, sb, rs, ao, ill};
   endfunction

   // Apply inputs just after a rising edge; st/ill are the expected
   // state and illegal flag during the cycle that follows.
   task automatic step(input logic r, input logic [6:0] op, input logic mr,
                       input logic z, input logic [3:0] st, input logic ill);
      @(posedge clk);
      #1;
      rst       = r;
      opcode    = op;
      mem_ready = mr;
      zero      = z;
      exp_q.push_back(expect_vec(st, r, mr, z, ill));
   endtask

   // Monitor: compare one queued expectation per falling edge
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         exp_cur = exp_q.pop_front();
         vectors++;
         if (actual !== exp_cur) begin
            miscompares++;
            $display("FAIL vec%0d t=%0t: state actual=%0d required=%0d, outputs actual=%05h required=%05h",
                     vectors, $time, actual[18:15], exp_cur[18:15], actual, exp_cur);
         end
      end
   end

   initial begin
      rst = 1'b1; opcode = 7'd0; mem_ready = 1'b0; zero = 1'b0;

      // Reset held: everything zero
      step(1, O_R, 0, 0, T_FETCH, 0);
      step(1, O_R, 1, 0, T_FETCH, 0);

      // R-type
      step(0, O_R, 1, 0, T_FETCH,    0);
      step(0, O_R, 1, 0, T_DECODE,   0);
      step(0, O_R, 1, 0, T_EXECUTER, 0);
      step(0, O_R, 1, 0, T_ALUWB,    0);

      // I-type
      step(0, O_I, 1, 0, T_FETCH,    0);
      step(0, O_I, 1, 0, T_DECODE,   0);
      step(0, O_I, 1, 0, T_EXECUTEI, 0);
      step(0, O_I, 1, 0, T_ALUWB,    0);

      // Load with two wait cycles in MEMREAD (7 cycles)
      step(0, O_LOAD, 1, 0, T_FETCH,   0);
      step(0, O_LOAD, 1, 0, T_DECODE,  0);
      step(0, O_LOAD, 1, 0, T_MEMADR,  0);
      step(0, O_LOAD, 0, 0, T_MEMREAD, 0);
      step(0, O_LOAD, 0, 0, T_MEMREAD, 0);
      step(0, O_LOAD, 1, 0, T_MEMREAD, 0);
      step(0, O_LOAD, 1, 0, T_MEMWB,   0);

      // Store with a fetch wait and a write wait
      step(0, O_STORE, 0, 0, T_FETCH,    0);
      step(0, O_STORE, 1, 0, T_FETCH,    0);
      step(0, O_STORE, 1, 0, T_DECODE,   0);
      step(0, O_STORE, 1, 0, T_MEMADR,   0);
      step(0, O_STORE, 0, 0, T_MEMWRITE, 0);
      step(0, O_STORE, 1, 0, T_MEMWRITE, 0);

      // Branch taken, then not taken
      step(0, O_BEQ, 1, 1, T_FETCH,  0);
      step(0, O_BEQ, 1, 1, T_DECODE, 0);
      step(0, O_BEQ, 1, 1, T_BEQ,    0);
      step(0, O_BEQ, 1, 0, T_FETCH,  0);
      step(0, O_BEQ, 1, 0, T_DECODE, 0);
      step(0, O_BEQ, 1, 0, T_BEQ,    0);

      // JAL
      step(0, O_JAL, 1, 0, T_FETCH,  0);
      step(0, O_JAL, 1, 0, T_DECODE, 0);
      step(0, O_JAL, 1, 0, T_JAL,    0);
      step(0, O_JAL, 1, 0, T_ALUWB,  0);

      // Illegal opcode: one-cycle flag during the next FETCH
      step(0, O_SYS, 1, 0, T_FETCH,  0);
      step(0, O_SYS, 1, 0, T_DECODE, 0);
      step(0, O_R,   1, 0, T_FETCH,  1);
      step(0, O_R,   1, 0, T_DECODE, 0);
      step(0, O_R,   1, 0, T_EXECUTER, 0);
      step(0, O_R,   1, 0, T_ALUWB,  0);

      // Reset asserted mid-MEMWRITE aborts at once
      step(0, O_STORE, 1, 0, T_FETCH,    0);
      step(0, O_STORE, 1, 0, T_DECODE,   0);
      step(0, O_STORE, 1, 0, T_MEMADR,   0);
      step(0, O_STORE, 0, 0, T_MEMWRITE, 0);
      step(1, O_STORE, 0, 0, T_FETCH,    0);
      step(1, O_R,     1, 0, T_FETCH,    0);
      step(0, O_R,     1, 0, T_FETCH,    0);
      step(0, O_R,     1, 0, T_DECODE,   0);
      step(0, O_R,     1, 0, T_EXECUTER, 0);

      repeat (2) @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: pending expectations actual=%0d required=0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle RV32I core. Sits directly upstream of alu_control.
- Decodes the latched opcode and sequences the datapath muxes and write strobes. Produces the 2-bit aluop that alu_control combines with {funct7[5], funct3} into alucmd.
- Handles a simple memory ready handshake and flags unsupported opcodes.

Parameters:
- STATE_W, 4, width of the state register (11 states used)

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- opcode  in  7  instruction[6:0] from the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- adrsrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- irwrite  out  1  instruction register load enable
- pcwrite  out  1  PC load enable
- regwrite  out  1  register file write enable
- memwrite  out  1  data memory write enable
- alusrca  out  2  ALU A select: 00 = PC, 01 = oldPC, 10 = rs1
- alusrcb  out  2  ALU B select: 00 = rs2, 01 = imm, 10 = constant 4
- resultsrc  out  2  result select: 00 = ALUOut, 01 = memory data, 10 = ALU result
- aluop  out  2  00 = add, 01 = subtract (compare), 10 = decode funct fields
- illegal_instr  out  1  one-cycle registered pulse on an unsupported opcode
- state_dbg  out  STATE_W  current state, for debug

Behaviour:
- Reset: rst asynchronously forces state to FETCH and clears illegal_instr. While rst is high, every output is 0: all strobes, all mux selects and aluop.
- Outputs are decoded from the state register (Moore). Two exceptions are Mealy terms:
  - irwrite and the fetch part of pcwrite are qualified by mem_ready.
  - pcwrite = pcupdate | (branch & zero).
- In every state, any output not listed below is 0.
- States, outputs and transitions:
  - FETCH: mem_req=1, adrsrc=0, alusrca=00, alusrcb=10, aluop=00, resultsrc=10. irwrite=pcupdate=mem_ready. Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
  - DECODE: alusrca=01, alusrcb=01, aluop=00 (precompute branch target into ALUOut). Next state by opcode:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1101111 -> JAL
    - 1100011 -> BEQ
    - any other opcode -> FETCH, with illegal_instr=1 on the following cycle
  - MEMADR: alusrca=10, alusrcb=01, aluop=00. Go to MEMREAD if opcode[5]=0, else MEMWRITE.
  - MEMREAD: mem_req=1, adrsrc=1. Wait while mem_ready=0; then go to MEMWB.
  - MEMWB: resultsrc=01, regwrite=1. Go to FETCH.
  - MEMWRITE: mem_req=1, adrsrc=1, memwrite=1. memwrite is held until mem_ready=1; then go to FETCH.
  - EXECUTER: alusrca=10, alusrcb=00, aluop=10. Go to ALUWB.
  - EXECUTEI: alusrca=10, alusrcb=01, aluop=10. Go to ALUWB.
  - ALUWB: resultsrc=00, regwrite=1. Go to FETCH.
  - JAL: alusrca=01, alusrcb=10, aluop=00, resultsrc=00, pcupdate=1. Go to ALUWB.
  - BEQ: alusrca=10, alusrcb=00, aluop=01, resultsrc=00, branch=1. Go to FETCH.
- Latency in cycles, with zero-wait memory:
  - R-type and I-type ALU: 4
  - lw: 5
  - sw: 4
  - beq: 3
  - jal: 4
- Each mem_ready=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle. While waiting, outputs are held stable.
- opcode is sampled in DECODE and MEMADR only. The instruction register is stable after FETCH, so no extra latching is required.
- Unreachable state encodings return to FETCH on the next clock with all strobes 0.
- Reset asserted mid-instruction aborts immediately. No regwrite or memwrite may occur after rst rises.

Decomposition:
- Shared package rv_ctrl_pkg holds:
  - opcode constants: OP_LOAD, OP_STORE, OP_R, OP_I, OP_JAL, OP_BRANCH
  - aluop encodings: ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT (also used by alu_control)
  - mux select constants
  - the state enum
- One sub-module: multicycle_control_decode, a pure combinational state-to-outputs decoder. The top module keeps the state register, next-state logic and the illegal_instr flop.

Test Plan:
- Reset: rst=1 mid-MEMWRITE -> state_dbg=FETCH immediately and memwrite=0. Release rst with mem_ready=1 -> mem_req=1 and irwrite=1 on the first cycle.
- R-type: opcode=0110011, mem_ready=1 -> states FETCH, DECODE, EXECUTER, ALUWB. aluop=10 in EXECUTER. regwrite=1 only in ALUWB.
- Load with wait: opcode=0000011, mem_ready=0 for 2 cycles in MEMREAD -> state held with adrsrc=1 and mem_req=1 while waiting, then MEMWB with resultsrc=01 and regwrite=1. Total 7 cycles.
- Branch: opcode=1100011 with zero=1 -> pcwrite=1 in BEQ with aluop=01. Repeat with zero=0 -> pcwrite=0. Both return to FETCH after 3 cycles.
- Store and jump: opcode=0100011 -> memwrite=1 in MEMWRITE only, regwrite never 1. opcode=1101111 -> pcwrite=1 in JAL, then regwrite=1 in ALUWB.
- Illegal: opcode=1110011 -> DECODE goes to FETCH, illegal_instr=1 for exactly one cycle, no regwrite, memwrite or pcwrite issued for that instruction.
